mul1_host_if: RTL and testbench
===============================

Name: mul1_host_if

Overview:
- Upstream sequencer for the repeated-addition multiplier (datapath + control path pair).
- Accepts an operand pair (A, B) on a valid/ready handshake and clears the multiplier.
- Serialises A then B onto the multiplier's shared 16-bit data bus with start asserted, then captures the product on done.
- Returns the product on a valid/ready result handshake, with a watchdog that flags a hung multiplier.

Parameters:
- W, 16, operand/product width (matches multiplier bus)
- A_HOLD, 2, cycles A is driven on mul_din before switching to B
- TIMEOUT_CYC, 70000, max cycles in WAIT before error; must exceed 2^W + 8

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  operand pair valid
- op_ready  out  1  block can accept an operand pair
- op_a  in  W  multiplicand
- op_b  in  W  multiplier (iteration count)
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  W  product (low W bits as produced by multiplier)
- res_err  out  1  result invalid due to timeout (qualifies res_valid)
- mul_clr  out  1  drives multiplier reset
- mul_start  out  1  drives multiplier start
- mul_din  out  W  drives multiplier data bus
- mul_done  in  1  multiplier done
- mul_y  in  W  multiplier product register

Behaviour:
- States: IDLE, CLR, LOAD_A, WAIT, RESP.
- Reset values while reset=1: state IDLE; op_ready=0; res_valid=0; res_data=0; res_err=0; mul_start=0; mul_din=0; mul_clr=1; operand and counter regs 0.
  - mul_clr = reset OR (state==CLR).
  - op_ready = (state==IDLE) AND NOT reset.
- IDLE:
  - op_ready=1.
  - On op_valid&&op_ready, latch op_a/op_b into a_q/b_q and go to CLR.
- CLR (1 cycle):
  - mul_clr=1, mul_start=0.
  - Next state LOAD_A; counter cleared.
- LOAD_A (A_HOLD cycles):
  - mul_start=1, mul_din=a_q.
  - Counter counts to A_HOLD-1, then go to WAIT.
- WAIT:
  - mul_start=1, mul_din=b_q.
  - Watchdog counter increments each cycle.
  - mul_done sampled 1: res_data<=mul_y, res_err<=0, go to RESP.
  - Counter reaches TIMEOUT_CYC-1 with mul_done=0: res_data<=0, res_err<=1, go to RESP.
  - mul_done and timeout in the same cycle: done wins.
- RESP:
  - res_valid=1; mul_start=0.
  - res_data and res_err are held stable until res_valid&&res_ready.
  - On handshake, go to IDLE; res_valid drops the next cycle.
  - Multiplier is left in its done state; the next op's CLR clears it.
- Latency:
  - Accept edge to first mul_start cycle = 2 cycles (accept, CLR).
  - res_valid rises on the edge after mul_done is first sampled high.
- Backpressure: res_ready=0 holds RESP indefinitely; op_ready stays 0; no new operand is accepted.
- No pipelining: exactly one operation in flight.
- Zero operands: no special case. The result is whatever the multiplier reports on done (required 0).
- Width: product truncation/overflow is the multiplier's behaviour; this block passes mul_y unchanged.
- Reset mid-operation (any state):
  - Immediate return to IDLE.
  - mul_clr asserts asynchronously with reset.
  - Pending operands and results are discarded.
- mul_done outside WAIT is ignored.
- All outputs except mul_clr and op_ready are registered.

Decomposition:
- Shared include mul1_defs.vh: state encodings, W default, counter width CNT_W = clog2(TIMEOUT_CYC)+1.
- The include is reused by the multiplier control path and this block.
- One natural sub-module: mul1_wdog.
  - Inputs: clk, reset, clr, en.
  - Outputs: cnt, expired at TIMEOUT_CYC-1.
  - Also reused for the A_HOLD count via a parameter.

Test Plan:
- op_a=17, op_b=5 with real multiplier, res_ready=1 -> mul_din=17 for 2 start cycles then 5; one res_valid pulse with res_data=85, res_err=0; op_ready=1 again after handshake.
- op_a=0, op_b=9 then op_a=9, op_b=0 back-to-back (op_valid held high) -> two results, both 0, in order; mul_clr pulses exactly once per operation.
- op_a=3, op_b=4, res_ready=0 for 20 cycles after res_valid -> res_valid and res_data=12 held stable; op_ready=0 throughout; completes on res_ready=1.
- Stubbed multiplier with mul_done stuck 0, TIMEOUT_CYC=50 -> res_valid exactly 50 cycles after WAIT entry with res_err=1, res_data=0.
- reset pulsed 3 cycles into WAIT of 100*200 -> mul_clr=1 asynchronously, res_valid never asserts for that op; a new op 7*6 afterwards returns 42.
- mul_done stub pulsed in IDLE and in the same cycle as timeout -> IDLE pulse ignored; simultaneous case returns mul_y with res_err=0.

Source files
------------

// File: rtl/mul1_host_if_pkg.sv
// Shared definitions for the repeated-addition multiplier host sequencer:
// state encoding, default sizing and counter-width helper.
package mul1_host_if_pkg;

  localparam int W_DEF       = 16;
  localparam int A_HOLD_DEF  = 2;
  localparam int TIMEOUT_DEF = 70000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/mul1_host_if_if.sv
// Operand/result handshakes plus the multiplier drive bus, bundled for the host sequencer.
interface mul1_host_if_if
  import mul1_host_if_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_err;

  logic         mul_clr;
  logic         mul_start;
  logic [W-1:0] mul_din;
  logic         mul_done;
  logic [W-1:0] mul_y;

  // slave: the sequencer itself
  modport slave (
    input  op_valid, op_a, op_b, res_ready, mul_done, mul_y,
    output op_ready, res_valid, res_data, res_err, mul_clr, mul_start, mul_din
  );

  // master: operand producer, result consumer and the multiplier
  modport master (
    output op_valid, op_a, op_b, res_ready, mul_done, mul_y,
    input  op_ready, res_valid, res_data, res_err, mul_clr, mul_start, mul_din
  );

endinterface

// File: rtl/mul1_host_if_wdog.sv
// Saturating up-counter that flags when it sits at LIMIT-1; used both for the
// A hold time and for the WAIT watchdog.
module mul1_host_if_wdog
  import mul1_host_if_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF,
  parameter int CNT_W = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mul1_host_if.sv
// Host sequencer for the repeated-addition multiplier: takes an operand pair,
// clears the multiplier, drives A then B with start, and returns the product.
//
//   state   | meaning
//   IDLE    | ready for an operand pair
//   CLR     | multiplier held in clear for one cycle
//   LOAD_A  | start high, A on the bus for A_HOLD cycles
//   WAIT    | start high, B on the bus, watchdog running
//   RESP    | result (or timeout error) offered until accepted
module mul1_host_if
  import mul1_host_if_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int A_HOLD      = A_HOLD_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input logic            clk,
  input logic            reset,
  mul1_host_if_if.slave  host
);

  state_e       state_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         res_valid_q;
  logic [W-1:0] res_data_q;
  logic         res_err_q;
  logic         mul_start_q;
  logic [W-1:0] mul_din_q;

  logic hold_expired;
  logic wd_expired;

  mul1_host_if_wdog #(.LIMIT(A_HOLD)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q != ST_LOAD_A),
    .en      (state_q == ST_LOAD_A),
    .expired (hold_expired)
  );

  mul1_host_if_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q != ST_WAIT),
    .en      (state_q == ST_WAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      mul_start_q <= 1'b0;
      mul_din_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (host.op_valid) begin
            a_q     <= host.op_a;
            b_q     <= host.op_b;
            state_q <= ST_CLR;
          end
        end
        ST_CLR: begin
          mul_start_q <= 1'b1;
          mul_din_q   <= a_q;
          state_q     <= ST_LOAD_A;
        end
        ST_LOAD_A: begin
          if (hold_expired) begin
            mul_din_q <= b_q;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // done has priority over a watchdog expiry in the same cycle
          if (host.mul_done) begin
            res_data_q  <= host.mul_y;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            mul_start_q <= 1'b0;
            state_q     <= ST_RESP;
          end else if (wd_expired) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            mul_start_q <= 1'b0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (host.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // clear and ready follow reset combinationally so they act the instant reset rises
  assign host.mul_clr   = reset | (state_q == ST_CLR);
  assign host.op_ready  = (state_q == ST_IDLE) & ~reset;
  assign host.mul_start = mul_start_q;
  assign host.mul_din   = mul_din_q;
  assign host.res_valid = res_valid_q;
  assign host.res_data  = res_data_q;
  assign host.res_err   = res_err_q;

endmodule

// File: tb/tb_mul1_host_if.sv
// Scoreboard bench for mul1_host_if: a behavioural repeated-addition multiplier
// (or a stub) sits on the bus, expected products come from plain arithmetic.
module tb_mul1_host_if;

  localparam int W      = 16;
  localparam int A_HOLD = 2;
  localparam int TO     = 300;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mul1_host_if_if #(.W(W)) bus ();

  mul1_host_if #(.W(W), .A_HOLD(A_HOLD), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .host  (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   rr_mode     = 0;
  int   clr_cycles  = 0;
  bit   stub        = 1'b0;
  logic stub_done   = 1'b0;
  logic [W-1:0] stub_y = '0;

  // behavioural multiplier: A on the first start cycles, B after A_HOLD, then repeated addition
  logic [W-1:0] m_a = '0, m_y = '0, m_left = '0;
  logic         m_done = 1'b0;
  int           m_ph = 0;

  always @(posedge clk) begin
    if (bus.mul_clr) begin
      m_a <= '0; m_y <= '0; m_left <= '0; m_done <= 1'b0; m_ph <= 0;
    end else if (bus.mul_start && !m_done) begin
      if (m_ph < A_HOLD) begin
        if (m_ph == 0) m_a <= bus.mul_din;
        m_ph <= m_ph + 1;
      end else if (m_ph == A_HOLD) begin
        m_left <= bus.mul_din;
        m_ph   <= m_ph + 1;
      end else if (m_left == '0) begin
        m_done <= 1'b1;
      end else begin
        m_y    <= m_y + m_a;
        m_left <= m_left - 1'b1;
      end
    end
  end

  assign bus.mul_done = stub ? stub_done : m_done;
  assign bus.mul_y    = stub ? stub_y    : m_y;

  function automatic logic [W-1:0] ref_mul(input int unsigned a, input int unsigned b);
    int unsigned p;
    p = a * b;
    return p[W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rr_mode)
      0:       bus.res_ready = 1'b1;
      1:       bus.res_ready = ($urandom_range(0, 3) != 0);
      default: bus.res_ready = 1'b0;
    endcase
  end

  // monitor: scoreboard pop on result handshake, plus hold-stability under backpressure
  logic         pv = 1'b0, phs = 1'b0, pe = 1'b0;
  logic [W-1:0] pd = '0;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
      phs = 1'b0;
    end else begin
      if (bus.mul_clr) clr_cycles++;
      if (bus.res_valid && pv && !phs) begin
        check("res_data_stable", bus.res_data, pd);
        check("res_err_stable", bus.res_err, pe);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got %0h, expected no result", bus.res_data);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          check("res_data", bus.res_data, x.d);
          check("res_err", bus.res_err, x.e);
        end
      end
      pv  = bus.res_valid;
      phs = bus.res_valid && bus.res_ready;
      pd  = bus.res_data;
      pe  = bus.res_err;
    end
  end

  // issue one operand pair, queue its expected result, and follow it onto the multiplier bus
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ed, input logic ee, input bit hold);
    int   n;
    exp_t t;
    n = 0;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    while (!bus.op_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      bound_fail("op_accept");
      bus.op_valid = 1'b0;
      return;
    end
    t.d = ed;
    t.e = ee;
    exp_q.push_back(t);
    @(posedge clk); #1;
    if (!hold) bus.op_valid = 1'b0;
    check("clr_cycle_mul_clr", bus.mul_clr, 1);
    check("clr_cycle_mul_start", bus.mul_start, 0);
    @(posedge clk); #1;
    check("load_a_start", bus.mul_start, 1);
    check("load_a_din0", bus.mul_din, a);
    @(posedge clk); #1;
    check("load_a_din1", bus.mul_din, a);
    @(posedge clk); #1;
    check("wait_start", bus.mul_start, 1);
    check("wait_din", bus.mul_din, b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) bound_fail("result_drain");
    @(negedge clk);
  endtask

  initial begin
    #200_000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int clr_base;
    logic [W-1:0] ra, rb;
    bit hold;

    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.res_ready = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_ready", bus.op_ready, 0);
    check("rst_mul_clr", bus.mul_clr, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_err", bus.res_err, 0);
    check("rst_mul_start", bus.mul_start, 0);
    check("rst_mul_din", bus.mul_din, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_op_ready", bus.op_ready, 1);
    check("idle_mul_clr", bus.mul_clr, 0);

    // basic product
    rr_mode = 0;
    send(17, 5, ref_mul(17, 5), 1'b0, 1'b0);
    drain();
    check("op_ready_after_resp", bus.op_ready, 1);

    // zero operands back-to-back with op_valid held
    clr_base = clr_cycles;
    send(0, 9, ref_mul(0, 9), 1'b0, 1'b1);
    send(9, 0, ref_mul(9, 0), 1'b0, 1'b0);
    drain();
    check("clr_per_op", clr_cycles - clr_base, 2);

    // backpressure on the result
    rr_mode = 2;
    send(3, 4, ref_mul(3, 4), 1'b0, 1'b0);
    n = 0;
    while (!bus.res_valid && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= TO + 50) bound_fail("bp_res_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_data", bus.res_data, 12);
      check("bp_op_ready", bus.op_ready, 0);
    end
    rr_mode = 0;
    drain();

    // watchdog timeout with a silent multiplier
    stub = 1'b1;
    stub_done = 1'b0;
    stub_y = 16'h5A5A;
    send(5, 5, '0, 1'b1, 1'b0);
    n = 0;
    while (!bus.res_valid && n < TO + 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_latency", n, TO);
    drain();

    // done arriving in the very cycle the watchdog expires
    stub_y = 16'hBEEF;
    send(1, 2, 16'hBEEF, 1'b0, 1'b0);
    repeat (TO - 1) @(posedge clk);
    #1 stub_done = 1'b1;
    @(posedge clk); #1;
    stub_done = 1'b0;
    check("simul_res_valid", bus.res_valid, 1);
    drain();

    // done pulse while idle must be ignored
    @(negedge clk);
    stub_y = 16'h1234;
    stub_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_done_op_ready", bus.op_ready, 1);
      check("idle_done_res_valid", bus.res_valid, 0);
    end
    stub_done = 1'b0;
    stub = 1'b0;

    // reset in the middle of WAIT
    send(100, 200, ref_mul(100, 200), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_mul_clr", bus.mul_clr, 1);
    check("midrst_op_ready", bus.op_ready, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(7, 6, ref_mul(7, 6), 1'b0, 1'b0);
    drain();

    // randomized traffic against the arithmetic reference
    rr_mode = 1;
    clr_base = clr_cycles;
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom_range(0, 65535));
      rb = W'($urandom_range(0, 40));
      hold = (i != 24) && ($urandom_range(0, 1) == 1);
      send(ra, rb, ref_mul(ra, rb), 1'b0, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("rand_clr_per_op", clr_cycles - clr_base, 25);
    rr_mode = 0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
